// File: rtl/pcla_pkg.sv
// rtl/pcla_pkg.sv - shared constants and reference 4-bit carry-look-ahead for the pipelined adder
package pcla_pkg;

    localparam int GROUP_W = 4;

    // Returns {cout, sum4} of a4 + b4 + c.
    function automatic logic [GROUP_W:0] cla4(
        input logic [GROUP_W-1:0] a4,
        input logic [GROUP_W-1:0] b4,
        input logic               c
    );
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] p;
        logic [GROUP_W:0]   cc;
        g     = a4 & b4;
        p     = a4 ^ b4;
        cc[0] = c;
        for (int i = 0; i < GROUP_W; i++) begin
            cc[i+1] = g[i] | (p[i] & cc[i]);
        end
        return {cc[GROUP_W], p ^ cc[GROUP_W-1:0]};
    endfunction

endpackage

// File: rtl/cla4_group.sv
// rtl/cla4_group.sv - combinational 4-bit carry-look-ahead group (two-level carries plus sum)
module cla4_group
    import pcla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c,
    output logic [GROUP_W-1:0] s,
    output logic               co
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic               c1;
    logic               c2;
    logic               c3;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of G/P and the group carry-in.
    assign c1 = g[0] | (p[0] & c);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);

    assign s = p ^ {c3, c2, c1, c};

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - WIDTH-bit add/sub, one 4-bit CLA group per pipeline stage, global stall
// Optional signed-overflow output enabled by defining PCLA_OVF_EN.
module pipelined_cla_adder
    import pcla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PCLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / GROUP_W;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage k adds bit group k; completed sum bits grow by one group per stage.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int RW = WIDTH - GROUP_W * k;
        localparam int DW = GROUP_W * (k + 1);

        logic [RW-1:0]      a_d;
        logic [RW-1:0]      b_d;
        logic               c_d;
        logic               v_d;
        logic [DW-1:0]      s_d;
        logic [DW-1:0]      s_q;
        logic [GROUP_W-1:0] gs;
        logic               gc;
        logic               c_q;
        logic               v_q;
`ifdef PCLA_OVF_EN
        logic               sa_d;
        logic               sb_d;
        logic               sa_q;
        logic               sb_q;
`endif

        if (k == 0) begin : g_first
            assign a_d = a;
            assign b_d = sub ? ~b : b;
            assign c_d = sub ? 1'b1 : cin;
            assign v_d = in_valid;
            assign s_d = gs;
`ifdef PCLA_OVF_EN
            assign sa_d = a[WIDTH-1];
            assign sb_d = b_d[WIDTH-1];
`endif
        end else begin : g_next
            assign a_d = rem[k-1].a_q;
            assign b_d = rem[k-1].b_q;
            assign c_d = stg[k-1].c_q;
            assign v_d = stg[k-1].v_q;
            assign s_d = {gs, stg[k-1].s_q};
`ifdef PCLA_OVF_EN
            assign sa_d = stg[k-1].sa_q;
            assign sb_d = stg[k-1].sb_q;
`endif
        end

        cla4_group u_cla (
            .a  (a_d[GROUP_W-1:0]),
            .b  (b_d[GROUP_W-1:0]),
            .c  (c_d),
            .s  (gs),
            .co (gc)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q  <= '0;
                c_q  <= 1'b0;
                v_q  <= 1'b0;
`ifdef PCLA_OVF_EN
                sa_q <= 1'b0;
                sb_q <= 1'b0;
`endif
            end else if (advance) begin
                s_q  <= s_d;
                c_q  <= gc;
                v_q  <= v_d;
`ifdef PCLA_OVF_EN
                sa_q <= sa_d;
                sb_q <= sb_d;
`endif
            end
        end
    end

    // Operand skew: bits not yet consumed travel alongside their op.
    for (genvar k = 0; k < STAGES - 1; k++) begin : rem
        localparam int RN = WIDTH - GROUP_W * (k + 1);

        logic [RN-1:0] a_q;
        logic [RN-1:0] b_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (advance) begin
                a_q <= stg[k].a_d[GROUP_W +: RN];
                b_q <= stg[k].b_d[GROUP_W +: RN];
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].s_q;
    assign cout      = stg[STAGES-1].c_q;

`ifdef PCLA_OVF_EN
    assign ovf = (stg[STAGES-1].sa_q == stg[STAGES-1].sb_q) && (sum[WIDTH-1] != stg[STAGES-1].sa_q);
`endif

endmodule
